// File: rtl/mipi_csi2_tx_packetizer.sv
// mipi_csi2_tx_packetizer
//   Builds CSI-2 packets for a 2-lane D-PHY byte transmitter in one byte-clock
//   domain: Frame Start / Frame End short packets and long line packets
//   (header, ECC, 16-bit payload stream, CRC). Each packet opens with the HS
//   sync byte on both lanes and is followed by an idle gap.
//
//   Optional feature macro: MIPI_TX_CRC_EN
//     defined   -> payload CRC-16 (0x8408 reflected, seed FFFF) is computed
//     undefined -> CRC logic is not built; the CRC slot carries 8'h00/8'h00
//
//   Timing: every output is a register. O_Pix_Ready leads the lanes by one
//   cycle -- it is high in each cycle whose closing edge can take a payload
//   word, so the first word follows the header with no idle cycle.
module mipi_csi2_tx_packetizer #(
  parameter logic [1:0] VC         = 2'd0,
  parameter logic [5:0] DT         = 6'h1E,
  parameter logic [7:0] SYNC_BYTE  = 8'hB8,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic        I_Clk,
  input  logic        I_Rst,
  input  logic        I_Cmd_Valid,
  input  logic [1:0]  I_Cmd_Type,
  input  logic [15:0] I_Cmd_WC,
  output logic        O_Cmd_Ready,
  input  logic [15:0] I_Pix_Data,
  input  logic        I_Pix_Valid,
  output logic        O_Pix_Ready,
  output logic [7:0]  O_Lane0_Data,
  output logic [7:0]  O_Lane1_Data,
  output logic        O_HS_Valid,
  output logic        O_Cmd_Err,
  output logic        O_Underflow
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SYNC    = 3'd1;
  localparam logic [2:0] S_HDR0    = 3'd2;
  localparam logic [2:0] S_HDR1    = 3'd3;
  localparam logic [2:0] S_PAYLOAD = 3'd4;
  localparam logic [2:0] S_CRC     = 3'd5;
  localparam logic [2:0] S_GAP     = 3'd6;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  logic [2:0]  state;
  logic        is_long;
  logic        is_fe;
  logic [7:0]  hdr_di;
  logic [15:0] hdr_wc;
  logic [7:0]  hdr_ecc;
  logic [14:0] remaining;
  logic [15:0] frame_cnt;
  logic [7:0]  gap_cnt;

  logic        cmd_accept;
  logic        cmd_bad;
  logic [7:0]  new_di;
  logic [15:0] new_wc;

`ifdef MIPI_TX_CRC_EN
  logic [15:0] crc_q;

  // Absorb one payload word, lane0 byte first, each byte LSB first.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                             input logic [15:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 16; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction
`endif

  // CSI-2 header ECC: 6 Hamming parity bits over {WC_hi, WC_lo, DI}.
  function automatic logic [7:0] ecc6(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return {2'b00, p};
  endfunction

  // Decode the offered command into header fields and a reject flag.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cmd_bad = 1'b0;
    new_di  = {VC, DT};
    new_wc  = I_Cmd_WC;
    case (I_Cmd_Type)
      2'd0: begin
        new_di = {VC, 6'h00};
        new_wc = frame_cnt;
      end
      2'd1: begin
        new_di = {VC, 6'h01};
        new_wc = frame_cnt;
      end
      2'd2:    cmd_bad = (I_Cmd_WC == 16'd0) | I_Cmd_WC[0];
      default: cmd_bad = 1'b1;
    endcase
  end

  assign cmd_accept = I_Cmd_Valid & O_Cmd_Ready;

  // Packet FSM; lane registers hold the bytes of the state currently shown.
  always_ff @(posedge I_Clk or posedge I_Rst) begin
    // NOTE: state registers use non-blocking assignments so every read in this block sees pre-edge values.
    if (I_Rst) begin
      state        <= S_IDLE;
      is_long      <= 1'b0;
      is_fe        <= 1'b0;
      hdr_di       <= 8'h00;
      hdr_wc       <= 16'h0000;
      hdr_ecc      <= 8'h00;
      remaining    <= 15'd0;
      frame_cnt    <= 16'd1;
      gap_cnt      <= 8'd0;
      O_Cmd_Ready  <= 1'b0;
      O_Pix_Ready  <= 1'b0;
      O_Lane0_Data <= 8'h00;
      O_Lane1_Data <= 8'h00;
      O_HS_Valid   <= 1'b0;
      O_Cmd_Err    <= 1'b0;
      O_Underflow  <= 1'b0;
`ifdef MIPI_TX_CRC_EN
      crc_q        <= 16'hFFFF;
`endif
    end else begin
      O_Cmd_Err <= 1'b0;
      case (state)
        S_IDLE: begin
          O_Cmd_Ready <= 1'b1;
          if (cmd_accept) begin
            if (cmd_bad) begin
              O_Cmd_Err <= 1'b1;
            end else begin
              state        <= S_SYNC;
              O_Cmd_Ready  <= 1'b0;
              O_Lane0_Data <= SYNC_BYTE;
              O_Lane1_Data <= SYNC_BYTE;
              O_HS_Valid   <= 1'b1;
              hdr_di       <= new_di;
              hdr_wc       <= new_wc;
              hdr_ecc      <= ecc6({new_wc, new_di});
              is_long      <= (I_Cmd_Type == 2'd2);
              is_fe        <= (I_Cmd_Type == 2'd1);
              remaining    <= I_Cmd_WC[15:1];
`ifdef MIPI_TX_CRC_EN
              crc_q        <= 16'hFFFF;
`endif
            end
          end
        end
        S_SYNC: begin
          state        <= S_HDR0;
          O_Lane0_Data <= hdr_di;
          O_Lane1_Data <= hdr_wc[7:0];
        end
        S_HDR0: begin
          state        <= S_HDR1;
          O_Lane0_Data <= hdr_wc[15:8];
          O_Lane1_Data <= hdr_ecc;
          O_Pix_Ready  <= is_long;
        end
        S_HDR1, S_PAYLOAD: begin
          if (!is_long) begin
            state        <= S_GAP;
            O_HS_Valid   <= 1'b0;
            O_Lane0_Data <= 8'h00;
            O_Lane1_Data <= 8'h00;
            gap_cnt      <= GAP_LAST;
          end else if (O_Pix_Ready) begin
            state <= S_PAYLOAD;
            if (I_Pix_Valid) begin
              O_Lane0_Data <= I_Pix_Data[7:0];
              O_Lane1_Data <= I_Pix_Data[15:8];
              O_HS_Valid   <= 1'b1;
              remaining    <= remaining - 15'd1;
              O_Pix_Ready  <= (remaining != 15'd1);
`ifdef MIPI_TX_CRC_EN
              crc_q        <= crc16_word(crc_q, I_Pix_Data);
`endif
            end else begin
              // Source stalled: lanes hold, burst pauses, flag is sticky.
              O_HS_Valid  <= 1'b0;
              O_Underflow <= 1'b1;
            end
          end else begin
            // Last word is on the lanes; the checksum follows directly.
            state        <= S_CRC;
            O_HS_Valid   <= 1'b1;
`ifdef MIPI_TX_CRC_EN
            O_Lane0_Data <= crc_q[7:0];
            O_Lane1_Data <= crc_q[15:8];
`else
            O_Lane0_Data <= 8'h00;
            O_Lane1_Data <= 8'h00;
`endif
          end
        end
        S_CRC: begin
          state        <= S_GAP;
          O_HS_Valid   <= 1'b0;
          O_Lane0_Data <= 8'h00;
          O_Lane1_Data <= 8'h00;
          gap_cnt      <= GAP_LAST;
        end
        S_GAP: begin
          if (gap_cnt == 8'd0) begin
            state       <= S_IDLE;
            O_Cmd_Ready <= 1'b1;
            if (is_fe) begin
              frame_cnt <= (frame_cnt == 16'hFFFF) ? 16'd1 : frame_cnt + 16'd1;
            end
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
